// File: rtl/fe_fifo_packer_if.sv
// Front-end event strobe, capture FIFO port and overflow status of the FIFO packer.
// slave = the packer; master = whatever drives events and observes the FIFO side.
interface fe_fifo_packer_if;
    logic        I_fifo_wr;
    logic [1:0]  I_fifo_command;
    logic [15:0] I_fifo_time;
    logic [7:0]  I_fifo_data;
    logic        I_arm;
    logic        I_flush;
    logic        I_fifo_full;
    logic [17:0] O_fifo_din;
    logic        O_fifo_wr_en;
    logic        O_overflow_blocked;
    logic [15:0] O_drop_count;
    logic        O_empty;

    modport slave (
        input  I_fifo_wr, I_fifo_command, I_fifo_time, I_fifo_data,
        input  I_arm, I_flush, I_fifo_full,
        output O_fifo_din, O_fifo_wr_en, O_overflow_blocked, O_drop_count, O_empty
    );

    modport master (
        output I_fifo_wr, I_fifo_command, I_fifo_time, I_fifo_data,
        output I_arm, I_flush, I_fifo_full,
        input  O_fifo_din, O_fifo_wr_en, O_overflow_blocked, O_drop_count, O_empty
    );
endinterface

// File: rtl/fe_fifo_packer.sv
// Packs front-end events into 18-bit capture FIFO words through a small elastic buffer;
// push to earliest write is one cycle, and on overflow drops/counts events and appends one marker.
module fe_fifo_packer #(
    parameter int          pTIMESTAMP_FULL_WIDTH  = 16,
    parameter int          pTIMESTAMP_SHORT_WIDTH = 3,
    parameter int          pDEPTH                 = 4,
    parameter logic [15:0] pOVF_MARKER            = 16'hFFFF
) (
    input logic             fe_clk,
    input logic             reset_i,
    fe_fifo_packer_if.slave bus
);
    localparam logic [1:0] CMD_TIME = 2'b01;
    localparam logic [1:0] CMD_STAT = 2'b10;
    localparam int AW = $clog2(pDEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {PASS, DRAIN, MARK, BLOCKED} state_t;

    state_t          state, state_nxt;
    logic [17:0]     mem [pDEPTH];
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count;
    logic            arm_r;
    logic            blocked;
    logic [15:0]     drop_count;

    logic            empty, buf_full, arm_edge, clear;
    logic            wr_en, pop, push_ok, drop;
    logic [17:0]     din, word;
    logic [7:0]      ts_short;

    assign empty    = (count == '0);
    assign buf_full = (count == CW'(pDEPTH));
    assign arm_edge = bus.I_arm & ~arm_r;
    assign clear    = bus.I_flush | arm_edge;

    // Only the low timestamp bits ride along with non-TIME events.
    always_comb begin
        ts_short = 8'(bus.I_fifo_time[pTIMESTAMP_SHORT_WIDTH-1:0]);
        if (bus.I_fifo_command == CMD_TIME)
            word = {bus.I_fifo_command, bus.I_fifo_time[pTIMESTAMP_FULL_WIDTH-1:0]};
        else
            word = {bus.I_fifo_command, ts_short, bus.I_fifo_data};
    end

    always_comb begin
        wr_en = 1'b0;
        din   = '0;
        if (state == MARK) begin
            din   = {CMD_STAT, pOVF_MARKER};
            wr_en = ~bus.I_fifo_full & ~bus.I_flush;
        end else if (!empty) begin
            din   = mem[rd_ptr];
            wr_en = ~bus.I_fifo_full & ~bus.I_flush & (state != BLOCKED);
        end
    end

    // A pop on a full buffer frees the slot the same-cycle push lands in.
    assign pop     = wr_en & (state != MARK);
    assign push_ok = bus.I_fifo_wr & ~clear & (state == PASS) & (~buf_full | pop);
    assign drop    = bus.I_fifo_wr & ~clear & ~push_ok;

    always_comb begin
        state_nxt = state;
        case (state)
            PASS:    if (drop)  state_nxt = DRAIN;
            DRAIN:   if (empty) state_nxt = MARK;
            MARK:    if (wr_en) state_nxt = BLOCKED;
            BLOCKED: state_nxt = BLOCKED;
            default: state_nxt = PASS;
        endcase
        if (clear)
            state_nxt = PASS;
    end

    always_ff @(posedge fe_clk) begin
        if (reset_i) begin
            state      <= PASS;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            arm_r      <= 1'b0;
            blocked    <= 1'b0;
            drop_count <= '0;
        end else begin
            state <= state_nxt;
            arm_r <= bus.I_arm;
            if (clear) begin
                rd_ptr     <= '0;
                wr_ptr     <= '0;
                count      <= '0;
                blocked    <= 1'b0;
                drop_count <= '0;
            end else begin
                if (push_ok)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                count <= count + CW'(push_ok) - CW'(pop);
                if (drop) begin
                    blocked <= 1'b1;
                    if (drop_count != 16'hFFFF)
                        drop_count <= drop_count + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge fe_clk) begin
        if (push_ok)
            mem[wr_ptr] <= word;
    end

    assign bus.O_fifo_din         = din;
    assign bus.O_fifo_wr_en       = wr_en;
    assign bus.O_overflow_blocked = blocked;
    assign bus.O_drop_count       = drop_count;
    assign bus.O_empty            = empty;
endmodule

// File: tb/tb_fe_fifo_packer.sv
// Scoreboard bench for fe_fifo_packer: expected words queued at push, compared at each FIFO write.
module tb_fe_fifo_packer;
    localparam logic [1:0] CMD_DATA = 2'b00;
    localparam logic [1:0] CMD_TIME = 2'b01;
    localparam logic [1:0] CMD_STAT = 2'b10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fe_fifo_packer_if bus();

    fe_fifo_packer #(
        .pTIMESTAMP_FULL_WIDTH (16),
        .pTIMESTAMP_SHORT_WIDTH(3),
        .pDEPTH                (4),
        .pOVF_MARKER           (16'hFFFF)
    ) dut (
        .fe_clk (clk),
        .reset_i(rst),
        .bus    (bus.slave)
    );

    int tests  = 0;
    int fails  = 0;
    int writes = 0;
    logic [17:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [17:0] pack(input logic [1:0] c, input logic [15:0] t, input logic [7:0] d);
        if (c == CMD_TIME) return {c, t};
        return {c, 5'b00000, t[2:0], d};
    endfunction

    always @(negedge clk) begin
        if (!rst && bus.O_fifo_wr_en === 1'b1) begin
            writes++;
            if (exp_q.size() == 0)
                check("unexpected_wr_queue", 0, 1);
            else
                check("wr_word", bus.O_fifo_din, exp_q.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] c, input logic [15:0] t, input logic [7:0] d, input bit expect_out);
        bus.I_fifo_wr      = 1'b1;
        bus.I_fifo_command = c;
        bus.I_fifo_time    = t;
        bus.I_fifo_data    = d;
        if (expect_out) exp_q.push_back(pack(c, t, d));
        step();
        bus.I_fifo_wr = 1'b0;
    endtask

    task automatic push_rand(input bit expect_out);
        push(2'($urandom_range(0, 3)), 16'($urandom), 8'($urandom), expect_out);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || bus.O_empty !== 1'b1) && n < budget) begin
            step();
            n++;
        end
        check("drain_left", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        rst = 1'b1;
        bus.I_fifo_wr = 1'b0; bus.I_fifo_command = '0; bus.I_fifo_time = '0; bus.I_fifo_data = '0;
        bus.I_arm = 1'b0; bus.I_flush = 1'b0; bus.I_fifo_full = 1'b0;
        step(); step();
        check("rst_empty", bus.O_empty, 1);
        check("rst_wr_en", bus.O_fifo_wr_en, 0);
        check("rst_din", bus.O_fifo_din, 0);
        check("rst_blocked", bus.O_overflow_blocked, 0);
        check("rst_drop", bus.O_drop_count, 0);
        rst = 1'b0;
        step();

        // Single data event: one-cycle latency, single write
        w0 = writes;
        push(CMD_DATA, 16'h0005, 8'hA5, 1);
        check("lat_wr_en", bus.O_fifo_wr_en, 1);
        check("lat_din", bus.O_fifo_din, 18'h005A5);
        step();
        check("single_wr_en_low", bus.O_fifo_wr_en, 0);
        check("single_writes", writes - w0, 1);

        // TIME event keeps full timestamp
        push(CMD_TIME, 16'h1234, 8'h77, 1);
        check("time_din", bus.O_fifo_din, 18'h11234);
        drain(20);

        // Random mix without back-pressure
        for (int i = 0; i < 10; i++) push_rand(1);
        drain(40);

        // Back-pressure up to depth, no loss
        bus.I_fifo_full = 1'b1;
        for (int i = 0; i < 4; i++) push_rand(1);
        check("bp_wr_en", bus.O_fifo_wr_en, 0);
        bus.I_fifo_full = 1'b0;
        drain(40);
        check("bp_blocked", bus.O_overflow_blocked, 0);
        check("bp_drop", bus.O_drop_count, 0);

        // Full buffer with a pop every cycle
        bus.I_fifo_full = 1'b1;
        for (int i = 0; i < 4; i++) push_rand(1);
        bus.I_fifo_full = 1'b0;
        for (int i = 0; i < 20; i++) push_rand(1);
        drain(40);
        check("fullpop_drop", bus.O_drop_count, 0);
        check("fullpop_blocked", bus.O_overflow_blocked, 0);

        // Overflow: 4 kept, 3 dropped, then marker
        bus.I_fifo_full = 1'b1;
        for (int i = 0; i < 7; i++) push_rand(i < 4);
        check("ovf_blocked", bus.O_overflow_blocked, 1);
        check("ovf_drop", bus.O_drop_count, 3);
        exp_q.push_back({CMD_STAT, 16'hFFFF});
        bus.I_fifo_full = 1'b0;
        drain(40);
        check("ovf_blocked_after", bus.O_overflow_blocked, 1);
        check("ovf_drop_after", bus.O_drop_count, 3);
        w0 = writes;
        push_rand(0); push_rand(0);
        step(); step();
        check("blk_drop", bus.O_drop_count, 5);
        check("blk_writes", writes - w0, 0);

        // Arm rising edge recovers
        bus.I_arm = 1'b1;
        step();
        check("arm_blocked", bus.O_overflow_blocked, 0);
        check("arm_drop", bus.O_drop_count, 0);
        step();
        bus.I_arm = 1'b0;
        push(CMD_DATA, 16'h0003, 8'h3C, 1);
        drain(20);

        // Flush with two buffered words and a same-cycle push
        bus.I_fifo_full = 1'b1;
        push_rand(0); push_rand(0);
        check("pre_flush_empty", bus.O_empty, 0);
        bus.I_fifo_full = 1'b0;
        bus.I_flush = 1'b1;
        bus.I_fifo_wr = 1'b1;
        check("flush_wr_en", bus.O_fifo_wr_en, 0);
        step();
        bus.I_flush = 1'b0;
        bus.I_fifo_wr = 1'b0;
        check("flush_empty", bus.O_empty, 1);
        check("flush_drop", bus.O_drop_count, 0);
        check("flush_blocked", bus.O_overflow_blocked, 0);
        step();
        check("flush_wr_en_after", bus.O_fifo_wr_en, 0);

        // Reset in the middle of a drain
        bus.I_fifo_full = 1'b1;
        for (int i = 0; i < 5; i++) push_rand(i < 4);
        bus.I_fifo_full = 1'b0;
        step();
        bus.I_fifo_full = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
        bus.I_fifo_full = 1'b0;
        check("rst_mid_blocked", bus.O_overflow_blocked, 0);
        check("rst_mid_drop", bus.O_drop_count, 0);
        check("rst_mid_empty", bus.O_empty, 1);
        check("rst_mid_wr_en", bus.O_fifo_wr_en, 0);
        push(CMD_TIME, 16'hBEEF, 8'h00, 1);
        drain(20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
